// File: rtl/mult_div_ctrl_if.sv
// Handshake and result bus between the main control FSM and the MULT/DIV sequencer.
interface mult_div_ctrl_if #(parameter int WIDTH = 32);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic             hi_lo_write;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // control FSM side: issues requests, watches status and HI/LO
  modport master (
    output start, op, a_in, b_in,
    input  busy, done, hi_lo_write, div_zero, hi, lo
  );

  // sequencer side
  modport slave (
    input  start, op, a_in, b_in,
    output busy, done, hi_lo_write, div_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_ctrl.sv
// Multicycle signed MULT/DIV sequencer: magnitude shift-add / restoring
// division over WIDTH steps, sign fix-up, then a one-cycle done pulse.
module mult_div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic          clock,
  input  logic          reset,
  mult_div_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, LOAD, MULT_STEP, DIV_STEP, FIX_SIGN, DONE} state_e;

  state_e               state_q, state_d;
  logic                 op_q, op_d;
  logic                 sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH:0]       rem_q, rem_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic                 hlw_q, hlw_d, dz_q, dz_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;

  logic                 last_step, b_zero;
  logic [WIDTH:0]       sum;
  logic [WIDTH+1:0]     shifted, diff;
  logic [2*WIDTH-1:0]   prod;

  // b_q still holds the raw captured operand while in LOAD
  assign last_step = (cnt_q == CNT_W'(WIDTH-1));
  assign b_zero    = (b_q == '0);

  // state and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hlw_q    <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hlw_q    <= hlw_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // next-state: start is only looked at in IDLE, so requests while busy drop
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (bus.start) state_d = LOAD;
      LOAD:      state_d = (op_q && b_zero) ? DONE : (op_q ? DIV_STEP : MULT_STEP);
      MULT_STEP: if (last_step) state_d = FIX_SIGN;
      DIV_STEP:  if (last_step) state_d = FIX_SIGN;
      FIX_SIGN:  state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // registered status: pulses are set on the edge entering DONE and drop on the way out
  always_comb begin
    busy_d = (state_d != IDLE);
    done_d = (state_q == FIX_SIGN) || (state_q == LOAD && op_q && b_zero);
    hlw_d  = (state_q == FIX_SIGN);
    dz_d   = (state_q == LOAD && op_q && b_zero);
  end

  // datapath: capture, magnitudes, one iteration per cycle, sign fix-up into HI/LO
  always_comb begin
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (b_q[0] ? a_q : '0)};
    // rem_q[WIDTH] is always 0 after a step, so the top bit only carries the borrow
    shifted  = {rem_q, a_q[WIDTH-1]};
    diff     = shifted - {2'b00, b_q};
    prod     = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    case (state_q)
      IDLE: if (bus.start) begin
        a_d  = bus.a_in;
        b_d  = bus.b_in;
        op_d = bus.op;
      end
      LOAD: begin
        sign_a_d = a_q[WIDTH-1];
        sign_b_d = b_q[WIDTH-1];
        // MIN_INT negates to itself, which is the correct unsigned magnitude 2^(WIDTH-1)
        a_d      = a_q[WIDTH-1] ? -a_q : a_q;
        b_d      = b_q[WIDTH-1] ? -b_q : b_q;
        acc_d    = '0;
        rem_d    = '0;
        cnt_d    = '0;
      end
      MULT_STEP: begin
        // add multiplicand into the upper half, shift product right; multiplier bits consumed LSB first
        acc_d = {sum, acc_q[WIDTH-1:1]};
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
      end
      DIV_STEP: begin
        // dividend shifts out MSB first while quotient bits shift in at the bottom
        if (!diff[WIDTH+1]) begin
          rem_d = diff[WIDTH:0];
          a_d   = {a_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH:0];
          a_d   = {a_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
      end
      FIX_SIGN: begin
        if (!op_q) begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else begin
          lo_d = (sign_a_q ^ sign_b_q) ? -a_q : a_q;
          hi_d = sign_a_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.hi_lo_write = hlw_q;
  assign bus.div_zero    = dz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
endmodule

// File: tb/tb_mult_div_ctrl.sv
// Directed bench for mult_div_ctrl: latency, signed results, div-by-zero,
// ignored requests while busy, and mid-operation reset.
module tb_mult_div_ctrl;
  logic clock = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  mult_div_ctrl_if #(.WIDTH(32)) bus ();
  mult_div_ctrl #(.WIDTH(32)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // full MULT/DIV: start edge E0, result visible after E34, idle after E35
  task automatic run_op(input string tag, input logic o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int nd;
    bus.op = o; bus.a_in = a; bus.b_in = b; bus.start = 1'b1;
    step();
    bus.start = 1'b0; bus.op = ~o; bus.a_in = 32'hDEADBEEF; bus.b_in = 32'h0BADF00D;
    chk({tag, "_busy_e0"}, 64'(bus.busy), 64'd1);
    nd = 0;
    repeat (33) begin
      step();
      if (bus.done) nd++;
    end
    chk({tag, "_early_done"}, 64'(nd), 64'd0);
    step();
    chk({tag, "_done"}, 64'(bus.done), 64'd1);
    chk({tag, "_hlw"}, 64'(bus.hi_lo_write), 64'd1);
    chk({tag, "_dz"}, 64'(bus.div_zero), 64'd0);
    chk({tag, "_hi"}, 64'(bus.hi), 64'(eh));
    chk({tag, "_lo"}, 64'(bus.lo), 64'(el));
    step();
    chk({tag, "_done_clr"}, 64'(bus.done), 64'd0);
    chk({tag, "_busy_clr"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int nd;
    reset = 1'b1; bus.start = 1'b0; bus.op = 1'b0; bus.a_in = '0; bus.b_in = '0;
    repeat (3) step();
    reset = 1'b0;
    repeat (5) step();
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_hlw", 64'(bus.hi_lo_write), 64'd0);
    chk("rst_dz", 64'(bus.div_zero), 64'd0);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);

    run_op("mul_7_m3", 1'b0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    run_op("mul_min_m1", 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    run_op("mul_min_min", 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0);
    run_op("div_m9_m4", 1'b1, 32'hFFFFFFF7, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'd2);
    // leaves hi=0x1234, lo=0x5678 for the divide-by-zero check
    run_op("div_setup", 1'b1, 32'h56781234, 32'h00010000, 32'h1234, 32'h5678);

    // divide by zero: pulses after E1, idle after E2, HI/LO untouched
    bus.op = 1'b1; bus.a_in = 32'd5; bus.b_in = 32'd0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    chk("dz_done", 64'(bus.done), 64'd1);
    chk("dz_flag", 64'(bus.div_zero), 64'd1);
    chk("dz_hlw", 64'(bus.hi_lo_write), 64'd0);
    chk("dz_hi", 64'(bus.hi), 64'h1234);
    chk("dz_lo", 64'(bus.lo), 64'h5678);
    chk("dz_busy", 64'(bus.busy), 64'd1);
    step();
    chk("dz_busy_clr", 64'(bus.busy), 64'd0);
    chk("dz_flag_clr", 64'(bus.div_zero), 64'd0);
    chk("dz_done_clr", 64'(bus.done), 64'd0);

    // MULT 3x4 with competing requests at E5 and E34/E35, all ignored
    bus.op = 1'b0; bus.a_in = 32'd3; bus.b_in = 32'd4; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    nd = 0;
    for (int c = 1; c <= 35; c++) begin
      if (c == 5) begin bus.start = 1'b1; bus.op = 1'b1; bus.a_in = 32'd9; bus.b_in = 32'd9; end
      if (c == 6) bus.start = 1'b0;
      if (c == 34) begin bus.start = 1'b1; bus.op = 1'b1; bus.a_in = 32'd100; bus.b_in = 32'd7; end
      step();
      if (bus.done) nd++;
    end
    bus.start = 1'b0;
    chk("ign_ndone", 64'(nd), 64'd1);
    chk("ign_hi", 64'(bus.hi), 64'd0);
    chk("ign_lo", 64'(bus.lo), 64'd12);
    chk("ign_busy", 64'(bus.busy), 64'd0);
    step();
    chk("ign_no_restart", 64'(bus.busy), 64'd0);

    // reset at cycle 20 of a MULT
    bus.op = 1'b0; bus.a_in = 32'h12345; bus.b_in = 32'h777; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (19) step();
    reset = 1'b1;
    step();
    chk("mrst_busy", 64'(bus.busy), 64'd0);
    chk("mrst_done", 64'(bus.done), 64'd0);
    chk("mrst_hi", 64'(bus.hi), 64'd0);
    chk("mrst_lo", 64'(bus.lo), 64'd0);
    reset = 1'b0;
    nd = 0;
    repeat (40) begin
      step();
      if (bus.done || bus.busy) nd++;
    end
    chk("mrst_quiet", 64'(nd), 64'd0);
    run_op("mul_2_2", 1'b0, 32'd2, 32'd2, 32'd0, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
